// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: instruction field layout,
// op encodings, one-hot ALU codes and the sequencer state enum.
package alu_seq_pkg;

  localparam int INST_W  = 16;
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 11;
  localparam int RS1_MSB = 10;
  localparam int RS1_LSB = 9;
  localparam int RS2_MSB = 8;
  localparam int RS2_LSB = 7;

  typedef logic [2:0] op_t;
  typedef logic [1:0] reg_field_t;

  localparam op_t OP_ADD = 3'd0;
  localparam op_t OP_SUB = 3'd1;
  localparam op_t OP_NOT = 3'd2;
  localparam op_t OP_AND = 3'd3;
  localparam op_t OP_MOV = 3'd4;
  localparam op_t OP_LDI = 3'd5;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD   = 4'b0001;
  localparam alu_op_t ALU_SUB   = 4'b0010;
  localparam alu_op_t ALU_NOT   = 4'b0100;
  localparam alu_op_t ALU_AND   = 4'b1000;
  localparam alu_op_t ALU_PASSB = 4'b0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic op_legal(input op_t op);
    return (op <= OP_LDI);
  endfunction

  // Illegal ops map to pass-B so the ALU sees a quiet code; the result is discarded.
  function automatic alu_op_t op_to_alu(input op_t op);
    alu_op_t code;
    case (op)
      OP_ADD:  code = ALU_ADD;
      OP_SUB:  code = ALU_SUB;
      OP_NOT:  code = ALU_NOT;
      OP_AND:  code = ALU_AND;
      default: code = ALU_PASSB;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Architectural register file for the sequencer: two combinational read ports,
// one synchronous write port, synchronous active-low clear of every entry.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREG  = 4,
  parameter int REG_W = $clog2(NREG)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [REG_W-1:0] waddr,
  input  logic [XLEN-1:0]  wdata,
  input  logic [REG_W-1:0] raddr1,
  output logic [XLEN-1:0]  rdata1,
  input  logic [REG_W-1:0] raddr2,
  output logic [XLEN-1:0]  rdata2
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    for (int i = 0; i < NREG; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // NOTE: clearing a memory array in reset blocks RAM inference; intended here, the file is tiny flops.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata1 = mem_q[raddr1];
  assign rdata2 = mem_q[raddr2];

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequencer that feeds the combinational ALU one instruction at a time:
// accept -> EXEC (drive ALU, write back) -> RESP (hold result until taken).
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREG  = 4,
  parameter int REG_W = $clog2(NREG)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_InstValid,
  output logic              io_InstReady,
  input  logic [INST_W-1:0] io_Inst,
  input  logic [XLEN-1:0]   io_Imm,
  output logic [XLEN-1:0]   io_AluA,
  output logic [XLEN-1:0]   io_AluB,
  output logic [3:0]        io_AluOp,
  input  logic [XLEN-1:0]   io_AluResult,
  output logic              io_ResValid,
  input  logic              io_ResReady,
  output logic [XLEN-1:0]   io_Result,
  output logic [REG_W-1:0]  io_ResReg,
  output logic              io_ResIllegal,
  output logic              io_Busy
);

  state_e state_q, state_d;

  op_t              op_q, op_d;
  logic [REG_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [REG_W-1:0] res_reg_q, res_reg_d;
  logic             res_illegal_q, res_illegal_d;

  op_t              inst_op;
  logic [REG_W-1:0] inst_rd, inst_rs1, inst_rs2;
  logic             inst_fire;
  logic             exec_legal;
  logic             rf_we;
  logic [XLEN-1:0]  rf_rdata1, rf_rdata2;
  logic             unused_inst_bits;

  assign inst_op   = io_Inst[OP_MSB:OP_LSB];
  assign inst_rd   = REG_W'(io_Inst[RD_MSB:RD_LSB]);
  assign inst_rs1  = REG_W'(io_Inst[RS1_MSB:RS1_LSB]);
  assign inst_rs2  = REG_W'(io_Inst[RS2_MSB:RS2_LSB]);
  assign unused_inst_bits = ^io_Inst[RS2_LSB-1:0];

  assign inst_fire  = io_InstValid && (state_q == IDLE);
  assign exec_legal = op_legal(op_q);

  // Write-back only at the end of a legal EXEC; the regfile's clear wins over this write.
  assign rf_we = (state_q == EXEC) && exec_legal;

  alu_seq_regfile #(
    .XLEN (XLEN),
    .NREG (NREG),
    .REG_W(REG_W)
  ) u_regfile (
    .clock (clock),
    .reset (reset),
    .we    (rf_we),
    .waddr (rd_q),
    .wdata (io_AluResult),
    .raddr1(inst_rs1),
    .rdata1(rf_rdata1),
    .raddr2(inst_rs2),
    .rdata2(rf_rdata2)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      op_q          <= '0;
      rd_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      result_q      <= '0;
      res_reg_q     <= '0;
      res_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      rd_q          <= rd_d;
      a_q           <= a_d;
      b_q           <= b_d;
      result_q      <= result_d;
      res_reg_q     <= res_reg_d;
      res_illegal_q <= res_illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (inst_fire) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (io_ResReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are captured at accept, so a later write to rs1/rs2 cannot disturb EXEC.
  always_comb begin
    op_d          = op_q;
    rd_d          = rd_q;
    a_d           = a_q;
    b_d           = b_q;
    result_d      = result_q;
    res_reg_d     = res_reg_q;
    res_illegal_d = res_illegal_q;
    case (state_q)
      IDLE: begin
        if (inst_fire) begin
          op_d = inst_op;
          rd_d = inst_rd;
          a_d  = '0;
          b_d  = '0;
          case (inst_op)
            OP_ADD, OP_SUB, OP_AND: begin
              a_d = rf_rdata1;
              b_d = rf_rdata2;
            end
            OP_NOT:  a_d = rf_rdata1;
            OP_MOV:  b_d = rf_rdata2;
            OP_LDI:  b_d = io_Imm;
            default: ;
          endcase
        end
      end
      EXEC: begin
        result_d      = exec_legal ? io_AluResult : '0;
        res_illegal_d = !exec_legal;
        res_reg_d     = rd_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    io_InstReady  = (state_q == IDLE);
    io_ResValid   = (state_q == RESP);
    io_Busy       = (state_q != IDLE);
    io_AluA       = '0;
    io_AluB       = '0;
    io_AluOp      = ALU_PASSB;
    if (state_q == EXEC) begin
      io_AluA  = a_q;
      io_AluB  = b_q;
      io_AluOp = op_to_alu(op_q);
    end
    io_Result     = result_q;
    io_ResReg     = res_reg_q;
    io_ResIllegal = res_illegal_q;
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: behavioural ALU on the ALU port and a
// scoreboard of expected responses pushed at accept, popped in RESP.
module tb_alu_op_sequencer;

  localparam int XLEN = 64;

  logic            clock = 1'b0;
  logic            reset;
  logic            io_InstValid;
  logic            io_InstReady;
  logic [15:0]     io_Inst;
  logic [XLEN-1:0] io_Imm;
  logic [XLEN-1:0] io_AluA;
  logic [XLEN-1:0] io_AluB;
  logic [3:0]      io_AluOp;
  logic [XLEN-1:0] io_AluResult;
  logic            io_ResValid;
  logic            io_ResReady;
  logic [XLEN-1:0] io_Result;
  logic [1:0]      io_ResReg;
  logic            io_ResIllegal;
  logic            io_Busy;

  typedef struct {
    logic [XLEN-1:0] result;
    logic [1:0]      rreg;
    logic            illegal;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};

  alu_op_sequencer #(.XLEN(XLEN), .NREG(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_InstValid (io_InstValid),
    .io_InstReady (io_InstReady),
    .io_Inst      (io_Inst),
    .io_Imm       (io_Imm),
    .io_AluA      (io_AluA),
    .io_AluB      (io_AluB),
    .io_AluOp     (io_AluOp),
    .io_AluResult (io_AluResult),
    .io_ResValid  (io_ResValid),
    .io_ResReady  (io_ResReady),
    .io_Result    (io_Result),
    .io_ResReg    (io_ResReg),
    .io_ResIllegal(io_ResIllegal),
    .io_Busy      (io_Busy)
  );

  always #5 clock = ~clock;

  // Combinational ALU: lowest set opcode bit wins, all-zero passes B.
  always_comb begin
    if      (io_AluOp[0]) io_AluResult = io_AluA + io_AluB;
    else if (io_AluOp[1]) io_AluResult = io_AluA - io_AluB;
    else if (io_AluOp[2]) io_AluResult = ~io_AluA;
    else if (io_AluOp[3]) io_AluResult = io_AluA & io_AluB;
    else                  io_AluResult = io_AluB;
  end

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                      input logic [1:0] rs2, input logic [XLEN-1:0] imm,
                      input logic [3:0] exp_alu, input logic check_ab,
                      input logic [XLEN-1:0] exp_a, input logic [XLEN-1:0] exp_b,
                      input logic [XLEN-1:0] exp_res, input logic exp_ill);
    int n;
    exp_t e;
    @(negedge clock);
    io_Inst      = {op, rd, rs1, rs2, 7'h55};
    io_Imm       = imm;
    io_InstValid = 1'b1;
    n = 0;
    while (!io_InstReady && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n == 20) check("accept_timeout", {63'd0, io_InstReady}, 64'd1);
    @(posedge clock);
    #1;
    io_InstValid = 1'b0;
    io_Inst      = 16'($urandom);
    io_Imm       = {$urandom, $urandom};
    e.result  = exp_res;
    e.rreg    = rd;
    e.illegal = exp_ill;
    sb_q.push_back(e);
    @(negedge clock);
    check("exec_aluop", io_AluOp, exp_alu);
    check("exec_resvalid", io_ResValid, 0);
    if (check_ab) begin
      check("exec_alua", io_AluA, exp_a);
      check("exec_alub", io_AluB, exp_b);
    end
  endtask

  task automatic collect(input int hold);
    exp_t e;
    @(negedge clock);
    check("resp_valid", io_ResValid, 1);
    check("resp_aluop_idle", io_AluOp, 0);
    if (sb_q.size() == 0) begin
      check("sb_underflow", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check("resp_result", io_Result, e.result);
      check("resp_reg", io_ResReg, e.rreg);
      check("resp_illegal", io_ResIllegal, e.illegal);
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        check("hold_valid", io_ResValid, 1);
        check("hold_result", io_Result, e.result);
        check("hold_reg", io_ResReg, e.rreg);
        check("hold_instready", io_InstReady, 0);
      end
    end
    io_InstValid = 1'b0;
    io_ResReady  = 1'b1;
    @(posedge clock);
    #1;
    io_ResReady = 1'b0;
    @(negedge clock);
    check("idle_instready", io_InstReady, 1);
    check("idle_busy", io_Busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    io_InstValid = 1'b0;
    io_Inst      = '0;
    io_Imm       = '0;
    io_ResReady  = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    @(negedge clock);
    check("rst_instready", io_InstReady, 1);
    check("rst_resvalid", io_ResValid, 0);
    check("rst_aluop", io_AluOp, 0);
    check("rst_alua", io_AluA, 0);
    check("rst_alub", io_AluB, 0);
    check("rst_result", io_Result, 0);
    check("rst_resreg", io_ResReg, 0);
    check("rst_illegal", io_ResIllegal, 0);
    check("rst_busy", io_Busy, 0);

    // op, rd, rs1, rs2, imm, aluop, check_ab, A, B, result, illegal
    send(3'd5, 2'd1, 2'd0, 2'd0, 64'd5, 4'b0000, 1, 0, 64'd5, 64'd5, 0);  collect(0);
    send(3'd5, 2'd2, 2'd0, 2'd0, 64'd3, 4'b0000, 1, 0, 64'd3, 64'd3, 0);  collect(0);
    send(3'd0, 2'd3, 2'd1, 2'd2, 64'd77, 4'b0001, 1, 64'd5, 64'd3, 64'd8, 0);  collect(0);
    send(3'd1, 2'd0, 2'd2, 2'd1, 0, 4'b0010, 1, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 0);  collect(0);

    send(3'd5, 2'd1, 2'd0, 2'd0, ONES, 4'b0000, 1, 0, ONES, ONES, 0);  collect(0);
    send(3'd5, 2'd2, 2'd0, 2'd0, 64'd1, 4'b0000, 1, 0, 64'd1, 64'd1, 0);  collect(0);
    send(3'd0, 2'd3, 2'd1, 2'd2, 0, 4'b0001, 1, ONES, 64'd1, 64'd0, 0);  collect(0);

    send(3'd5, 2'd1, 2'd0, 2'd0, 64'h00FF, 4'b0000, 1, 0, 64'h00FF, 64'h00FF, 0);  collect(0);
    send(3'd2, 2'd0, 2'd1, 2'd2, 0, 4'b0100, 1, 64'h00FF, 0, 64'hFFFF_FFFF_FFFF_FF00, 0);  collect(0);

    send(3'd5, 2'd1, 2'd0, 2'd0, 64'hF0F0, 4'b0000, 1, 0, 64'hF0F0, 64'hF0F0, 0);  collect(0);
    send(3'd5, 2'd2, 2'd0, 2'd0, 64'h0FF0, 4'b0000, 1, 0, 64'h0FF0, 64'h0FF0, 0);  collect(0);
    send(3'd3, 2'd3, 2'd1, 2'd2, 0, 4'b1000, 1, 64'hF0F0, 64'h0FF0, 64'h00F0, 0);  collect(0);
    send(3'd4, 2'd2, 2'd3, 2'd1, 0, 4'b0000, 1, 0, 64'hF0F0, 64'hF0F0, 0);  collect(0);
    send(3'd4, 2'd0, 2'd0, 2'd2, 0, 4'b0000, 1, 0, 64'hF0F0, 64'hF0F0, 0);  collect(0);

    // Illegal ops: flagged, zero result, destination untouched (read back by MOV).
    send(3'd6, 2'd3, 2'd1, 2'd2, 64'd123, 4'b0000, 0, 0, 0, 64'd0, 1);  collect(0);
    send(3'd4, 2'd0, 2'd0, 2'd3, 0, 4'b0000, 1, 0, 64'h00F0, 64'h00F0, 0);  collect(0);
    send(3'd7, 2'd1, 2'd2, 2'd3, 64'd456, 4'b0000, 0, 0, 0, 64'd0, 1);  collect(0);
    send(3'd4, 2'd0, 2'd0, 2'd1, 0, 4'b0000, 1, 0, 64'hF0F0, 64'hF0F0, 0);  collect(0);

    // Back-pressure: RESP held 5 cycles while a new instruction is offered.
    send(3'd5, 2'd2, 2'd0, 2'd0, 64'h1234, 4'b0000, 1, 0, 64'h1234, 64'h1234, 0);
    io_Inst      = {3'd0, 2'd3, 2'd1, 2'd2, 7'h00};
    io_InstValid = 1'b1;
    collect(5);
    send(3'd4, 2'd0, 2'd0, 2'd2, 0, 4'b0000, 1, 0, 64'h1234, 64'h1234, 0);  collect(0);
    send(3'd4, 2'd0, 2'd0, 2'd3, 0, 4'b0000, 1, 0, 64'h00F0, 64'h00F0, 0);  collect(0);

    // Reset asserted during EXEC of LDI r1,9: write dropped, no response.
    @(negedge clock);
    io_Inst      = {3'd5, 2'd1, 2'd0, 2'd0, 7'h00};
    io_Imm       = 64'd9;
    io_InstValid = 1'b1;
    @(posedge clock);
    #1;
    io_InstValid = 1'b0;
    @(negedge clock);
    check("abort_in_exec", io_Busy, 1);
    reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("abort_instready", io_InstReady, 1);
    check("abort_resvalid", io_ResValid, 0);
    check("abort_busy", io_Busy, 0);
    check("abort_result", io_Result, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("abort_no_resp", io_ResValid, 0);
    end
    send(3'd4, 2'd0, 2'd0, 2'd1, 0, 4'b0000, 1, 0, 64'd0, 64'd0, 0);  collect(0);

    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
